imm_ext_pipe: RTL and testbench
===============================

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, which sets the output immediate width and legal values 32 or 64.
REQ-002 The block SHALL have parameter CNT_W, default 8, which sets the width of the illegal-format counter.
REQ-003 The block SHALL have clk  input  1  as its single clock, with all state updating on the rising edge.
REQ-004 The block SHALL have rst  input  1  as its reset, asynchronous and active-high.
REQ-005 The block SHALL have in_valid  input  1, meaning the upstream request is valid.
REQ-006 The block SHALL have in_ready  output  1, meaning the block can accept a request this cycle.
REQ-007 The block SHALL have in_instr  input  25, carrying instruction bits [31:7], with bit 0 of the port equal to instruction bit 7.
REQ-008 The block SHALL have in_imm_src  input  3, carrying the immediate format select.
REQ-009 The block SHALL have flush  input  1, which discards all buffered results.
REQ-010 The block SHALL have out_valid  output  1, meaning out_imm and out_err are valid.
REQ-011 The block SHALL have out_ready  input  1, meaning downstream accepts the result.
REQ-012 The block SHALL have out_imm  output  XLEN, carrying the extended immediate.
REQ-013 The block SHALL have out_err  output  1, meaning the result came from an illegal format code.
REQ-014 The block SHALL have err_count  output  CNT_W, a saturating count of accepted illegal requests.

Function
REQ-015 Decode SHALL use the following formats, where S() means sign-extend to XLEN from instruction bit 31 and Z() means zero-extend:
- 000 I: S(i[31:20])
- 001 S: S(i[31:25],i[11:7])
- 010 B: S(i[31],i[7],i[30:25],i[11:8],0)
- 011 J: S(i[31],i[19:12],i[20],i[30:21],0)
- 100 U: S(i[31:12],12'b0)
- 101 shamt: Z(i[24:20]) when XLEN=32; Z(i[25:20]) when XLEN=64
- 110 CSR zimm: Z(i[19:15])
REQ-016 Code 111 SHALL produce out_imm = 0 and out_err = 1; all other codes SHALL produce out_err = 0.
REQ-017 A request SHALL be accepted when in_valid && in_ready && !flush.
REQ-018 Storage SHALL consist of one output register plus one skid register, each holding {imm, err, valid}.
REQ-019 in_ready SHALL equal !skid_valid, driven combinationally from state only.
REQ-020 Latency SHALL be exactly 1 cycle: a request accepted at edge N with the output stage empty or draining SHALL appear on out_valid/out_imm immediately after edge N.
REQ-021 A transfer out SHALL occur when out_valid && out_ready.
REQ-022 When a request is accepted while the output is full and not draining, the decoded result SHALL be written to the skid register.
REQ-023 When the output drains while the skid register is valid, the skid contents SHALL move to the output register and skid_valid SHALL clear; a simultaneous acceptance is impossible because in_ready = 0.
REQ-024 Simultaneous accept and drain with an empty skid SHALL load the new result into the output register, and out_valid SHALL stay 1.
REQ-025 Results SHALL leave in acceptance order, with no loss and no duplication.
REQ-026 out_imm and out_err SHALL hold stable while out_valid && !out_ready.
REQ-027 flush SHALL clear output and skid valids at the next edge, and any request presented in the flush cycle SHALL be dropped and not counted.
REQ-028 err_count SHALL increment by 1 for each accepted code-111 request and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-029 flush SHALL NOT clear err_count.

Reset
REQ-030 While rst = 1, out_valid, skid_valid, out_imm, out_err and err_count SHALL be 0, and in_ready SHALL be 1.
REQ-031 Reset SHALL take effect immediately, without waiting for a clock edge, including mid-transfer.
REQ-032 Buffered results present when reset is asserted SHALL be discarded.
REQ-033 The first acceptance SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-034 The bench SHALL apply XLEN=32, instr 0xFFF00093 (in_instr = bits [31:7]), src 000, out_ready=1 and check out_imm 0xFFFFFFFF, out_err 0, one cycle later.
REQ-035 The bench SHALL apply instr 0xFE000EE3 with src 010 and check out_imm 0xFFFFFFFC; then instr 0x800000B7 with src 100 at XLEN=64 and check 0xFFFFFFFF80000000.
REQ-036 The bench SHALL hold out_ready=0 and offer 3 back-to-back requests, then check that 2 are accepted, in_ready=0 on the third, the output holds the first value, and releasing out_ready delivers all 3 in order.
REQ-037 The bench SHALL send 260 code-111 requests with CNT_W=8 and check err_count=255, out_imm=0 and out_err=1 on each.
REQ-038 The bench SHALL fill both stages, assert flush together with a new request, then check out_valid=0 and in_ready=1 next cycle, and that the request is not delivered.
REQ-039 The bench SHALL assert rst asynchronously between edges with both stages full, then check that out_valid and err_count drop to 0 before the next edge.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// RISC-V immediate extractor with a one-deep output register plus skid buffer.
// Counts accepted illegal-format requests in a saturating counter.
module imm_ext_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0]      w_imm32;
  logic             w_sext;
  logic             w_err;
  logic             w_sign;
  logic [XLEN-1:0]  w_imm;
  logic             w_accept;
  logic             w_drain;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  logic             r_out_err;
  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  logic             r_skid_err;
  logic [CNT_W-1:0] r_err_count;

  // in_instr[k] holds instruction bit k+7
  assign w_sign = in_instr[24];

  always_comb begin
    w_imm32 = 32'b0;
    w_sext  = 1'b1;
    w_err   = 1'b0;
    case (in_imm_src)
      3'b000: w_imm32 = {{20{w_sign}}, in_instr[24:13]};
      3'b001: w_imm32 = {{20{w_sign}}, in_instr[24:18], in_instr[4:0]};
      3'b010: w_imm32 = {{19{w_sign}}, w_sign, in_instr[0], in_instr[23:18], in_instr[4:1], 1'b0};
      3'b011: w_imm32 = {{11{w_sign}}, w_sign, in_instr[12:5], in_instr[13], in_instr[23:14],
                         1'b0};
      3'b100: w_imm32 = {in_instr[24:5], 12'b0};
      3'b101: begin
        w_sext  = 1'b0;
        w_imm32 = (XLEN == 32) ? {27'b0, in_instr[17:13]} : {26'b0, in_instr[18:13]};
      end
      3'b110: begin
        w_sext  = 1'b0;
        w_imm32 = {27'b0, in_instr[12:8]};
      end
      default: begin
        w_sext = 1'b0;
        w_err  = 1'b1;
      end
    endcase
  end

  assign w_imm    = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);
  assign in_ready = !r_skid_valid;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_drain  = r_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_imm    <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_err   <= 1'b0;
      r_err_count  <= '0;
    end else begin
      if (flush) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_drain) begin
        if (r_skid_valid) begin
          r_out_imm    <= r_skid_imm;
          r_out_err    <= r_skid_err;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_out_imm <= w_imm;
          r_out_err <= w_err;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (!r_out_valid) begin
        if (w_accept) begin
          r_out_valid <= 1'b1;
          r_out_imm   <= w_imm;
          r_out_err   <= w_err;
        end
      end else if (w_accept) begin
        // Output full and stalled: park the new result in the skid slot
        r_skid_valid <= 1'b1;
        r_skid_imm   <= w_imm;
        r_skid_err   <= w_err;
      end

      if (w_accept && w_err && (r_err_count != {CNT_W{1'b1}})) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_imm   = r_out_imm;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench driving XLEN=32 and XLEN=64 instances with shared stimulus.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [24:0] in_instr;
  logic [2:0]  in_imm_src;
  logic        flush;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic [7:0]  err_count32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [7:0]  err_count64;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;

  logic [64:0] q32[$];
  logic [64:0] q64[$];
  logic [64:0] cur32;
  logic [64:0] cur64;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .flush(flush), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_err(out_err32), .err_count(err_count32)
  );

  imm_ext_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .flush(flush), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_err(out_err64), .err_count(err_count64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [2:0] src,
                       input logic [63:0] e32, input logic [63:0] e64);
    in_valid   = 1'b1;
    in_instr   = instr[31:7];
    in_imm_src = src;
    cur32      = {src == 3'b111, e32};
    cur64      = {src == 3'b111, e64};
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready32 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {63'b0, n >= 50}, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {63'b0, n >= 100}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Pops on a transfer about to happen at the next edge, pushes on an acceptance
  always @(negedge clk) begin
    logic [64:0] e;
    if (rst) begin
      q32.delete();
      q64.delete();
    end else begin
      if (out_valid32 && out_ready) begin
        check("sb32_nonempty", {63'b0, q32.size() != 0}, 64'd1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          check("imm32", {32'b0, out_imm32}, e[63:0]);
          check("err32", {63'b0, out_err32}, {63'b0, e[64]});
        end
      end
      if (out_valid64 && out_ready) begin
        check("sb64_nonempty", {63'b0, q64.size() != 0}, 64'd1);
        if (q64.size() != 0) begin
          e = q64.pop_front();
          check("imm64", out_imm64, e[63:0]);
          check("err64", {63'b0, out_err64}, {63'b0, e[64]});
        end
      end
      if (flush) begin
        q32.delete();
        q64.delete();
      end else if (in_valid && in_ready32) begin
        q32.push_back(cur32);
        q64.push_back(cur64);
        n_acc++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_imm_src = '0; flush = 1'b0;
    out_ready = 1'b0; cur32 = '0; cur64 = '0;
    #2;
    check("rst_out_valid", {63'b0, out_valid32}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready32}, 64'd1);
    check("rst_out_imm", {32'b0, out_imm32}, 64'd0);
    check("rst_out_err", {63'b0, out_err32}, 64'd0);
    check("rst_err_count", {56'b0, err_count64}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // First acceptance at the first edge after reset release, one-cycle latency
    out_ready = 1'b1;
    drive(32'hFFF0_0093, 3'b000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_accept();
    check("lat_valid", {63'b0, out_valid32}, 64'd1);
    check("lat_imm_i", {32'b0, out_imm32}, 64'hFFFF_FFFF);
    check("lat_err_i", {63'b0, out_err32}, 64'd0);
    drive(32'hFE00_0EE3, 3'b010, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_accept();
    check("lat_imm_b", {32'b0, out_imm32}, 64'hFFFF_FFFC);
    drive(32'h8000_00B7, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000);
    wait_accept();
    check("lat_imm_u64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    drive(32'h0011_2423, 3'b001, 64'd8, 64'd8);
    wait_accept();
    drive(32'hFFDF_F06F, 3'b011, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_accept();
    drive(32'h03F0_D093, 3'b101, 64'h1F, 64'h3F);
    wait_accept();
    drive(32'hFFFF_F073, 3'b110, 64'h1F, 64'h1F);
    wait_accept();
    drive(32'hFFFF_FFFF, 3'b111, 64'd0, 64'd0);
    wait_accept();
    wait_drain();
    check("err_count_one", {56'b0, err_count32}, 64'd1);

    // Backpressure: two accepted, third stalls, output held
    out_ready = 1'b0;
    n_acc = 0;
    drive(32'h0010_0093, 3'b000, 64'd1, 64'd1);
    wait_accept();
    drive(32'h0020_0093, 3'b000, 64'd2, 64'd2);
    wait_accept();
    drive(32'h0030_0093, 3'b000, 64'd3, 64'd3);
    #1;
    check("bp_in_ready", {63'b0, in_ready32}, 64'd0);
    check("bp_out_imm", {32'b0, out_imm32}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("bp_n_acc", n_acc, 64'd2);
    check("bp_hold_imm", {32'b0, out_imm32}, 64'd1);
    check("bp_hold_valid", {63'b0, out_valid32}, 64'd1);
    out_ready = 1'b1;
    wait_accept();
    wait_drain();
    check("bp_n_acc_all", n_acc, 64'd3);

    // Flush with both stages full and a request presented in the flush cycle
    out_ready = 1'b0;
    drive(32'h0040_0093, 3'b000, 64'd4, 64'd4);
    wait_accept();
    drive(32'h0050_0093, 3'b000, 64'd5, 64'd5);
    wait_accept();
    drive(32'h0060_0093, 3'b111, 64'd0, 64'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {63'b0, out_valid32}, 64'd0);
    check("flush_in_ready", {63'b0, in_ready32}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_no_output", {63'b0, out_valid32 | out_valid64}, 64'd0);
    end
    check("flush_err_count", {56'b0, err_count32}, 64'd1);
    @(posedge clk);
    #1;

    // Illegal-format saturation
    for (int i = 0; i < 260; i++) begin
      drive($urandom(), 3'b111, 64'd0, 64'd0);
      wait_accept();
    end
    wait_drain();
    check("sat_err_count32", {56'b0, err_count32}, 64'd255);
    check("sat_err_count64", {56'b0, err_count64}, 64'd255);

    // Asynchronous reset mid-cycle with both stages full
    out_ready = 1'b0;
    drive(32'h0070_0093, 3'b000, 64'd7, 64'd7);
    wait_accept();
    drive(32'h0080_0093, 3'b000, 64'd8, 64'd8);
    wait_accept();
    check("pre_rst_in_ready", {63'b0, in_ready32}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {63'b0, out_valid32}, 64'd0);
    check("arst_err_count", {56'b0, err_count32}, 64'd0);
    check("arst_in_ready", {63'b0, in_ready64}, 64'd1);
    check("arst_out_imm", out_imm64, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    drive(32'h0090_0093, 3'b000, 64'd9, 64'd9);
    wait_accept();
    check("post_rst_valid", {63'b0, out_valid32}, 64'd1);
    check("post_rst_imm", {32'b0, out_imm32}, 64'd9);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
